// File: rtl/carwash_input_ctrl_if.sv
// Car-wash front-end bus: raw buttons/switches in, clean pulses and package code out.
// master drives the raw inputs (board/testbench); slave is carwash_input_ctrl.
interface carwash_input_ctrl_if;
    logic       BTN3;
    logic       BTN0;
    logic       SW7;
    logic       SW6;
    logic       SW5;
    logic       start_pulse;
    logic       abort_pulse;
    logic       step_tick;
    logic [1:0] pkg;
    logic       busy;
    logic       done;

    modport master (
        output BTN3, BTN0, SW7, SW6, SW5,
        input  start_pulse, abort_pulse, step_tick, pkg, busy, done
    );

    modport slave (
        input  BTN3, BTN0, SW7, SW6, SW5,
        output start_pulse, abort_pulse, step_tick, pkg, busy, done
    );
endinterface

// File: rtl/carwash_input_ctrl.sv
// Car-wash input controller: 2-flop sync + debounce on BTN3/BTN0, package latch and a
// run-control FSM (IDLE/RUN/DONE) emitting registered start/abort/step pulses.
// Build option: define CARWASH_STEP_TIMER_EN for the automatic step timer; when it is
// undefined each debounced BTN3 press in RUN produces the step tick instead.
module carwash_input_ctrl #(
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned STEP_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    carwash_input_ctrl_if.slave   bus
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DebMax = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Index 0 = BTN3 (start/pay/step), index 1 = BTN0 (abort)
    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];
    logic [1:0]    press;
    logic          btn3_press, btn0_press;

    assign raw        = {bus.BTN0, bus.BTN3};
    assign btn3_press = press[0];
    assign btn0_press = press[1];

    // Debounce: count while the synced input disagrees; flip on the DEB_CYCLES-th sample.
    // The press event is the cycle the level flips to 1, so it fires once per press.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            press[i]     = 1'b0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebMax) begin
                    deb_d[i] = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Synchronizer and debounce state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
        end
    end

    // Package decode with SW7 > SW6 > SW5 priority, and its step count
    logic [1:0] pkg_sel;
    logic [3:0] pkg_steps;

    always_comb begin
        pkg_sel = 2'd0;
        if (bus.SW7)      pkg_sel = 2'd1;
        else if (bus.SW6) pkg_sel = 2'd2;
        else if (bus.SW5) pkg_sel = 2'd3;
        unique case (pkg_sel)
            2'd1:    pkg_steps = 4'd5;
            2'd2:    pkg_steps = 4'd7;
            2'd3:    pkg_steps = 4'd13;
            default: pkg_steps = 4'd0;
        endcase
    end

    state_e     state_q, state_d;
    logic [1:0] pkg_q, pkg_d;
    logic [3:0] steps_q, steps_d;
    logic       start_q, start_d;
    logic       abort_q, abort_d;
    logic       tick_q, tick_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       step_evt;

`ifdef CARWASH_STEP_TIMER_EN
    localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] TimerMax = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;

    assign step_evt = (timer_q == TimerMax);
`else
    assign step_evt = btn3_press;
`endif

    // Run-control next state. steps_left reaching 0 is acted on one cycle later so that
    // busy stays high through the final tick and done rises in the following cycle.
    always_comb begin
        state_d = state_q;
        pkg_d   = pkg_q;
        steps_d = steps_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        tick_d  = 1'b0;
`ifdef CARWASH_STEP_TIMER_EN
        timer_d = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (btn3_press && (pkg_sel != 2'd0)) begin
                    pkg_d   = pkg_sel;
                    steps_d = pkg_steps;
                    start_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
`ifdef CARWASH_STEP_TIMER_EN
                timer_d = step_evt ? '0 : timer_q + 1'b1;
`endif
                if (steps_q == 4'd0) begin
                    state_d = StDone;
                end else if (btn0_press) begin
                    // Abort wins over a coincident step event
                    abort_d = 1'b1;
                    pkg_d   = 2'd0;
                    steps_d = 4'd0;
                    state_d = StIdle;
                end else if (step_evt) begin
                    tick_d  = 1'b1;
                    steps_d = steps_q - 4'd1;
                end
            end
            StDone: begin
                if (btn3_press) begin
                    pkg_d   = 2'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pkg_q   <= 2'd0;
            steps_q <= 4'd0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CARWASH_STEP_TIMER_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pkg_q   <= pkg_d;
            steps_q <= steps_d;
            start_q <= start_d;
            abort_q <= abort_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CARWASH_STEP_TIMER_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign bus.start_pulse = start_q;
    assign bus.abort_pulse = abort_q;
    assign bus.step_tick   = tick_q;
    assign bus.pkg         = pkg_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_carwash_input_ctrl.sv
// Directed bench for carwash_input_ctrl (DEB_CYCLES=16, STEP_CYCLES=64).
// Follows CARWASH_STEP_TIMER_EN the same way the design does.
module tb_carwash_input_ctrl;

    logic clk;
    logic rst;

    carwash_input_ctrl_if bus ();

    carwash_input_ctrl #(
        .DEB_CYCLES  (16),
        .STEP_CYCLES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge
    int n_start = 0, n_abort = 0, n_tick = 0;
    int start_cyc = 0, abort_cyc = 0, tick_cyc = 0, done_cyc = 0, busy_fall_cyc = 0;
    int tick_log[$];
    logic done_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.start_pulse) begin n_start <= n_start + 1; start_cyc <= cyc; end
            if (bus.abort_pulse) begin n_abort <= n_abort + 1; abort_cyc <= cyc; end
            if (bus.step_tick) begin
                n_tick   <= n_tick + 1;
                tick_cyc <= cyc;
                tick_log.push_back(cyc);
            end
            if (bus.done && !done_prev) done_cyc <= cyc;
            if (!bus.busy && busy_prev) busy_fall_cyc <= cyc;
        end
        done_prev <= bus.done;
        busy_prev <= bus.busy;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean physical press: held long enough to debounce, then released
    task automatic press(input logic b3, input logic b0);
        bus.BTN3 = b3;
        bus.BTN0 = b0;
        cycles(22);
        bus.BTN3 = 1'b0;
        bus.BTN0 = 1'b0;
        cycles(22);
    endtask

    task automatic set_sw(input logic s7, input logic s6, input logic s5);
        bus.SW7 = s7;
        bus.SW6 = s6;
        bus.SW5 = s5;
    endtask

    function automatic logic [6:0] outs();
        return {bus.start_pulse, bus.abort_pulse, bus.step_tick, bus.pkg, bus.busy, bus.done};
    endfunction

    int hold;
    int base;
    int t0;

    initial begin
        rst      = 1'b1;
        bus.BTN3 = 1'b0;
        bus.BTN0 = 1'b0;
        set_sw(1'b0, 1'b0, 1'b0);
        cycles(3);
        check("reset_outputs", 32'(outs()), 0);
        rst = 1'b0;
        cycles(2);
        check("idle_after_reset", 32'(outs()), 0);

        // Bouncing BTN3 (5-cycle segments, last one low), then a steady hold; all
        // switches set so SW7 must win
        set_sw(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            bus.BTN3 = (i % 2 == 0);
            cycles(5);
        end
        bus.BTN3 = 1'b1;
        hold     = cyc;
        cycles(25);
        check("bounce_one_start", n_start, 1);
        check("bounce_latency", start_cyc - hold, 18);
        check("priority_pkg", bus.pkg, 1);
        check("run_busy", bus.busy, 1);
        bus.BTN3 = 1'b0;
        cycles(25);
        check("release_no_start", n_start, 1);

        // Switch changes while running must not touch pkg
        set_sw(1'b0, 1'b0, 1'b1);
`ifndef CARWASH_STEP_TIMER_EN
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        check("basic_ticks4", n_tick, 4);
        check("basic_busy_mid", bus.busy, 1);
        check("basic_done_mid", bus.done, 0);
        check("pkg_held_sw", bus.pkg, 1);
        press(1'b1, 1'b0);
        check("basic_ticks5", n_tick, 5);
        check("no_restart", n_start, 1);
`else
        cycles(5 * 64);
        check("basic_ticks5", n_tick, 5);
        check("pkg_held_sw", bus.pkg, 1);
        check("basic_first_gap", tick_log[0] - start_cyc, 64);
`endif
        check("basic_done", bus.done, 1);
        check("basic_busy_end", bus.busy, 0);
        check("done_after_tick", done_cyc - tick_cyc, 1);
        check("busy_fall_with_done", busy_fall_cyc - tick_cyc, 1);

        // DONE ignores BTN0; BTN3 returns to IDLE without a new wash
        press(1'b0, 1'b1);
        check("done_btn0_ignored", bus.done, 1);
        check("done_no_abort", n_abort, 0);
        press(1'b1, 1'b0);
        check("done_to_idle", {bus.pkg, bus.busy, bus.done}, 0);
        check("done_no_start", n_start, 1);

        // Null package select
        set_sw(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        check("null_no_start", n_start, 1);
        check("null_busy", bus.busy, 0);
        check("null_pkg", bus.pkg, 0);

`ifndef CARWASH_STEP_TIMER_EN
        // Extra package: seven presses, seven ticks, then done
        set_sw(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("extra_start", n_start, 2);
        check("extra_pkg", bus.pkg, 2);
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0);
        check("extra_ticks6", n_tick, 11);
        check("extra_busy6", bus.busy, 1);
        press(1'b1, 1'b0);
        check("extra_ticks7", n_tick, 12);
        check("extra_done", bus.done, 1);
        press(1'b1, 1'b0);
        check("extra_idle", bus.done, 0);

        // Abort and step press debounce in the same cycle: abort wins
        set_sw(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("prem_pkg", bus.pkg, 3);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("prem_ticks2", n_tick, 14);
        press(1'b1, 1'b1);
        check("collide_abort", n_abort, 1);
        check("collide_no_tick", n_tick, 14);
        check("collide_idle", {bus.pkg, bus.busy, bus.done}, 0);
`else
        // Premium run on the timer
        set_sw(1'b0, 1'b0, 1'b1);
        tick_log.delete();
        t0 = n_tick;
        press(1'b1, 1'b0);
        check("prem_pkg", bus.pkg, 3);
        cycles(13 * 64);
        check("prem_ticks", n_tick - t0, 13);
        check("prem_first_gap", tick_log[0] - start_cyc, 64);
        for (int i = 1; i < 13; i++) check("prem_gap", tick_log[i] - tick_log[i-1], 64);
        check("prem_done", done_cyc - tick_cyc, 1);
        press(1'b1, 1'b0);
        check("prem_idle", {bus.pkg, bus.busy, bus.done}, 0);

        // BTN0 press event lands on the third terminal count
        set_sw(1'b1, 1'b0, 1'b0);
        t0 = n_tick;
        press(1'b1, 1'b0);
        base = start_cyc;
        cycles(base + 174 - cyc);
        bus.BTN0 = 1'b1;
        cycles(30);
        bus.BTN0 = 1'b0;
        cycles(22);
        check("collide_abort", n_abort, 1);
        check("collide_cycle", abort_cyc - base, 192);
        check("collide_no_tick", n_tick - t0, 2);
        check("collide_idle", {bus.pkg, bus.busy, bus.done}, 0);
`endif

        // Asynchronous reset in the middle of a run
        set_sw(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        check("pre_reset_busy", bus.busy, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outs", 32'(outs()), 0);
        cycles(2);
        rst = 1'b0;
        cycles(2);
        t0 = n_start;
        press(1'b1, 1'b0);
        check("fresh_start", n_start - t0, 1);
        check("fresh_pkg", bus.pkg, 1);
        check("fresh_busy", bus.busy, 1);
`ifndef CARWASH_STEP_TIMER_EN
        t0 = n_tick;
        press(1'b1, 1'b0);
        check("fresh_tick", n_tick - t0, 1);
        check("fresh_still_busy", bus.busy, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
